// File: rtl/io_port_pkg.sv
// io_port_pkg: shared byte width, default FIFO depth and count-width helper for the CPU I/O port
package io_port_pkg;
  localparam int DEF_DATA_W = 8;
  localparam int DEF_DEPTH = 4;
  function automatic int cnt_w(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/sync_fifo.sv
// sync_fifo: DEPTH x DATA_W FIFO (push/pop/wdata in; rdata head, count, full, empty out); a push while full succeeds only alongside a pop
module sync_fifo
  import io_port_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  logic                   pop,
  input  logic [DATA_W-1:0]      wdata,
  output logic [DATA_W-1:0]      rdata,
  output logic [$clog2(DEPTH):0] count,
  output logic                   full,
  output logic                   empty
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = cnt_w(DEPTH);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] count_q, count_d;
  logic do_push, do_pop;
  always_comb begin
    full = count_q == CW'(DEPTH);
    empty = count_q == '0;
    do_pop = pop && !empty;
    do_push = push && (!full || do_pop);
    mem_d = mem_q;
    if (do_push) mem_d[wr_q] = wdata;
    rd_d = rd_q + AW'(do_pop);
    wr_d = wr_q + AW'(do_push);
    count_d = count_q + CW'(do_push) - CW'(do_pop);
    rdata = mem_q[rd_q];
    count = count_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rd_q <= '0;
      wr_q <= '0;
      count_q <= '0;
    end else begin
      rd_q <= rd_d;
      wr_q <= wr_d;
      count_q <= count_d;
    end
  always_ff @(posedge clk) mem_q <= mem_d;
endmodule

// File: rtl/cpu_io_port.sv
// cpu_io_port: host<->CPU byte bridge (RX: in_* -> cpu_i, TX: cpu_o -> out_*), occupancy counts, sticky underflow/overflow with clr_flags
module cpu_io_port
  import io_port_pkg::*;
#(
  parameter int DEPTH = DEF_DEPTH,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [DATA_W-1:0]      cpu_o,
  input  logic                   cpu_o_en,
  input  logic                   cpu_i_en,
  output logic [DATA_W-1:0]      cpu_i,
  input  logic [DATA_W-1:0]      in_data,
  input  logic                   in_valid,
  output logic                   in_ready,
  output logic [DATA_W-1:0]      out_data,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [$clog2(DEPTH):0] rx_count,
  output logic [$clog2(DEPTH):0] tx_count,
  output logic                   underflow,
  output logic                   overflow,
  input  logic                   clr_flags
);
  logic rx_empty, rx_full, tx_empty, tx_full, rx_push, tx_pop;
  logic underflow_q, underflow_d, overflow_q, overflow_d;
  logic [DATA_W-1:0] rx_head, tx_head;
  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_rx (
    .clk(clk), .rst(rst), .push(rx_push), .pop(cpu_i_en), .wdata(in_data),
    .rdata(rx_head), .count(rx_count), .full(rx_full), .empty(rx_empty)
  );
  sync_fifo #(.DEPTH(DEPTH), .DATA_W(DATA_W)) u_tx (
    .clk(clk), .rst(rst), .push(cpu_o_en), .pop(tx_pop), .wdata(cpu_o),
    .rdata(tx_head), .count(tx_count), .full(tx_full), .empty(tx_empty)
  );
  always_comb begin
    in_ready = !rx_full;
    rx_push = in_valid && in_ready;
    cpu_i = rx_empty ? '0 : rx_head;
    out_valid = !tx_empty;
    tx_pop = out_valid && out_ready;
    out_data = tx_empty ? '0 : tx_head;
    underflow_d = clr_flags ? 1'b0 : underflow_q | (cpu_i_en & rx_empty);
    overflow_d = clr_flags ? 1'b0 : overflow_q | (cpu_o_en & tx_full & !tx_pop);
    underflow = underflow_q;
    overflow = overflow_q;
  end
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      underflow_q <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      underflow_q <= underflow_d;
      overflow_q <= overflow_d;
    end
endmodule

// File: doc/cpu_io_port.md
CPU_IO_PORT -- requirements
Module: cpu_io_port

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning entries per FIFO; power of two, minimum 2.
REQ-002 SHALL have parameter DATA_W, default 8, meaning byte width; it matches the CPU I/O ports.
REQ-003 SHALL have port clk  input  1  single clock; all state updates on the rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-low (0 = reset).
REQ-005 SHALL have port cpu_o  input  DATA_W  byte driven by the CPU output port.
REQ-006 SHALL have port cpu_o_en  input  1  CPU output-enable; qualifies cpu_o as a write.
REQ-007 SHALL have port cpu_i_en  input  1  CPU input-enable; marks a CPU read of cpu_i.
REQ-008 SHALL have port cpu_i  output  DATA_W  byte presented to the CPU input port.
REQ-009 SHALL have port in_data  input  DATA_W  host byte destined for the CPU.
REQ-010 SHALL have port in_valid  input  1  host offers in_data.
REQ-011 SHALL have port in_ready  output  1  RX FIFO can accept a byte.
REQ-012 SHALL have port out_data  output  DATA_W  oldest CPU-written byte.
REQ-013 SHALL have port out_valid  output  1  TX FIFO holds at least one byte.
REQ-014 SHALL have port out_ready  input  1  host accepts out_data.
REQ-015 SHALL have port rx_count  output  $clog2(DEPTH)+1  RX FIFO occupancy.
REQ-016 SHALL have port tx_count  output  $clog2(DEPTH)+1  TX FIFO occupancy.
REQ-017 SHALL have port underflow  output  1  sticky flag: CPU read while RX was empty.
REQ-018 SHALL have port overflow  output  1  sticky flag: CPU write while TX was full.
REQ-019 SHALL have port clr_flags  input  1  synchronous clear of both sticky flags.

Function
REQ-020 RX path SHALL push in_data on an edge where in_valid and in_ready are both 1.
REQ-021 in_ready SHALL equal (rx_count < DEPTH).
REQ-022 cpu_i SHALL combinationally show the RX head; it SHALL be 0 when RX is empty.
REQ-023 RX SHALL pop on an edge where cpu_i_en is 1 and RX is non-empty.
REQ-024 An edge with cpu_i_en = 1 and RX empty SHALL set underflow; no pointer change.
REQ-025 TX SHALL push cpu_o on an edge where cpu_o_en is 1 and TX is not full.
REQ-026 An edge with cpu_o_en = 1 and TX full SHALL drop the byte and set overflow, unless a TX pop occurs on the same edge; in that case the push SHALL succeed.
REQ-027 out_valid SHALL equal (tx_count != 0); out_data SHALL be the TX head, or 0 when empty.
REQ-028 TX SHALL pop on an edge where out_valid and out_ready are both 1.
REQ-029 Simultaneous push and pop on a non-empty FIFO SHALL leave its count unchanged and preserve order.
REQ-030 A push into an empty RX SHALL NOT be visible on cpu_i until the following cycle; there is no fall-through on the same edge.
REQ-031 Pointers SHALL wrap modulo DEPTH; counts SHALL saturate at neither 0 nor DEPTH; over/underrun SHALL be impossible by construction.
REQ-032 clr_flags SHALL take priority over a same-edge flag set.
REQ-033 Latency from a host push to the byte appearing on cpu_i SHALL be 1 cycle; latency from a CPU write to out_valid SHALL be 1 cycle.

Reset
REQ-034 While rst = 0, the block SHALL hold rx_count = tx_count = 0, underflow = overflow = 0, cpu_i = 0, out_data = 0, out_valid = 0 and in_ready = 1.
REQ-035 Reset asserted mid-transfer SHALL discard all FIFO contents; deassertion SHALL be synchronous-release safe, with the first push accepted on the first edge after rst rises.

Structure
REQ-036 Package io_port_pkg SHALL hold DATA_W and the default DEPTH, plus the count-width function.
REQ-037 One sub-module, sync_fifo, SHALL implement DEPTH×DATA_W storage, pointers and count; it SHALL be instantiated twice, once for RX and once for TX.
REQ-038 cpu_io_port SHALL contain only the handshake glue, the zero-masking of empty outputs, and the sticky flags.

Verification
REQ-039 Scenario: reset, then host pushes 0x11, 0x22, 0x33; CPU reads 3 times -> cpu_i shows 0x11, 0x22, 0x33 in order, and rx_count goes 3→0.
REQ-040 Scenario: host pushes 5 bytes with DEPTH = 4 and no reads -> in_ready = 0 after 4 bytes, the 5th byte is held off, and rx_count = 4.
REQ-041 Scenario: CPU writes 0xA0..0xA4 with out_ready = 0 -> tx_count = 4, overflow = 1, and 0xA4 is lost; draining then yields 0xA0..0xA3.
REQ-042 Scenario: TX full, with cpu_o_en = 1 and out_ready = 1 on the same edge -> no overflow and tx_count stays 4.
REQ-043 Scenario: CPU read with RX empty -> cpu_i = 0 and underflow = 1; then clr_flags pulse -> underflow = 0.
REQ-044 Scenario: rst driven to 0 asynchronously with both FIFOs half full -> counts and flags are 0 immediately, before the next clk edge.
